// File: rtl/potential_adder_accum.sv
// Accumulates a stream of FP32 synaptic weights into a neuron's decayed membrane potential,
// with a small weight FIFO in front so the spike-dispatch side can burst without stalling.

module potential_adder_accum #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 12
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              start,
   input  logic [31:0]       base_potential,
   input  logic [ADDR_W-1:0] neuron_addr,
   input  logic              w_valid,
   input  logic [31:0]       w_data,
   input  logic              w_last,
   output logic              w_ready,
   output logic [31:0]       new_potential,
   output logic [ADDR_W-1:0] addr_out,
   output logic              done,
   output logic              busy,
   output logic              exc_flag
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [32:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [31:0]       acc_q, acc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              exc_q, exc_d;
   logic              push, pop, flush;
   logic [32:0]       head;
   logic [31:0]       sum;
   logic              add_exc;

   assign w_ready = (count_q != CNT_W'(FIFO_DEPTH));
   assign push    = w_valid & w_ready;
   assign pop     = (state_q == S_ACCUM) && (count_q != '0) && !start;
   // A restart mid-timestep discards queued weights, but keeps one arriving this same cycle.
   assign flush   = start && (state_q != S_IDLE);
   assign head    = fifo_mem[rd_ptr_q];

   Addition_Subtraction u_add (
      .a_i         (acc_q),
      .b_i         (head[31:0]),
      .sub_i       (1'b0),
      .result_o    (sum),
      .exception_o (add_exc)
   );

   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {w_last, w_data};
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = CNT_W'(push);
      end else begin
         rd_ptr_d = rd_ptr_q + PTR_W'(pop);
         count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      addr_d  = addr_q;
      exc_d   = exc_q;
      done    = 1'b0;
      case (state_q)
         S_IDLE:  if (start) state_d = S_ACCUM;
         S_ACCUM: if (!start && pop && head[32]) state_d = S_DONE;
         S_DONE: begin
            done    = !start;
            state_d = start ? S_ACCUM : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (start) begin
         acc_d  = base_potential;
         addr_d = neuron_addr;
         exc_d  = 1'b0;
      end else if (pop) begin
         acc_d = sum;
         if (add_exc) exc_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         acc_q    <= '0;
         addr_q   <= '0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         addr_q   <= addr_d;
         exc_q    <= exc_d;
      end
   end

   assign new_potential = acc_q;
   assign addr_out      = addr_q;
   assign busy          = (state_q != S_IDLE);
   assign exc_flag      = exc_q;

endmodule

// Combinational IEEE-754 single-precision add/subtract, round-to-nearest-even,
// gradual underflow; Exception flags overflow or any Inf/NaN operand.
module Addition_Subtraction (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        sub_i,
   output logic [31:0] result_o,
   output logic        exception_o
);

   logic        sa, sb, s_l, s_s, swap, sticky, round_up;
   logic [7:0]  ea, eb, e_l, e_s, e_diff;
   logic [23:0] ma, mb, m_l, m_s;
   logic [26:0] al, sm_ext, sm_shift, norm;
   logic [27:0] raw;
   logic [4:0]  lz, lsh;
   logic [9:0]  exp_n, exp_r;
   logic [24:0] mant_r;

   always_comb begin
      sa = a_i[31];
      sb = b_i[31] ^ sub_i;
      // Subnormals share the exponent of the smallest normal, without the hidden bit.
      ea = (a_i[30:23] == 8'd0) ? 8'd1 : a_i[30:23];
      eb = (b_i[30:23] == 8'd0) ? 8'd1 : b_i[30:23];
      ma = {a_i[30:23] != 8'd0, a_i[22:0]};
      mb = {b_i[30:23] != 8'd0, b_i[22:0]};

      swap = (b_i[30:0] > a_i[30:0]);
      s_l  = swap ? sb : sa;
      s_s  = swap ? sa : sb;
      e_l  = swap ? eb : ea;
      e_s  = swap ? ea : eb;
      m_l  = swap ? mb : ma;
      m_s  = swap ? ma : mb;

      e_diff = e_l - e_s;
      sm_ext = {m_s, 3'b000};
      if (e_diff >= 8'd27) begin
         sm_shift = '0;
         sticky   = |m_s;
      end else begin
         sm_shift = sm_ext >> e_diff;
         sticky   = |(sm_ext & ((27'd1 << e_diff) - 27'd1));
      end
      al = {m_l, 3'b000};
      if (s_l == s_s) raw = {1'b0, al} + {1'b0, sm_shift[26:1], sm_shift[0] | sticky};
      else            raw = {1'b0, al} - {1'b0, sm_shift[26:1], sm_shift[0] | sticky};

      lz = 5'd27;
      for (int i = 26; i >= 0; i--) begin
         if (raw[i] && lz == 5'd27) lz = 5'(26 - i);
      end

      lsh = 5'd0;
      if (raw[27]) begin
         norm    = raw[27:1];
         norm[0] = raw[1] | raw[0];
         exp_n   = {2'b00, e_l} + 10'd1;
      end else begin
         // Never shift below the minimum exponent; the remainder becomes subnormal.
         lsh   = ({5'd0, lz} < ({2'b00, e_l} - 10'd1)) ? lz : 5'(e_l - 8'd1);
         norm  = raw[26:0] << lsh;
         exp_n = {2'b00, e_l} - 10'(lsh);
      end

      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant_r   = {1'b0, norm[26:3]} + 25'(round_up);
      exp_r    = exp_n;
      if (mant_r[24]) begin
         mant_r = mant_r >> 1;
         exp_r  = exp_n + 10'd1;
      end
      if (!mant_r[23]) exp_r = 10'd0;

      exception_o = 1'b0;
      result_o    = {s_l, exp_r[7:0], mant_r[22:0]};
      if (raw == 28'd0) result_o = {s_l & s_s, 31'd0};
      if (a_i[30:23] == 8'hFF || b_i[30:23] == 8'hFF) begin
         exception_o = 1'b1;
         result_o    = 32'h7FC00000;
      end else if (exp_r >= 10'd255) begin
         exception_o = 1'b1;
         result_o    = {s_l, 8'hFF, 23'd0};
      end
   end

endmodule
